// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / MEM stage) arbiter onto one registered memory bus port.
// Optional bus timeout watchdog is compiled in when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter (
    input  logic        CLK,
    input  logic        RST,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,

    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,

    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wmask,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,

    output logic        stallreq_from_if,
    output logic        stallreq_from_mem,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic grant_mem;
    logic grant_if;
    logic finish;
    logic timeout;
    logic busy;

    assign busy = (state == BUSY_IF) || (state == BUSY_MEM);

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] timeout_cnt;

    // The 255th BUSY cycle without an ack ends the transaction.
    assign timeout = busy && !bus_ack && (timeout_cnt == 8'd254);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            timeout_cnt <= 8'd0;
            bus_err     <= 1'b0;
        end else begin
            if (grant_mem || grant_if) begin
                timeout_cnt <= 8'd0;
            end else if (busy && !bus_ack) begin
                timeout_cnt <= timeout_cnt + 8'd1;
            end
            if (timeout) begin
                bus_err <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        grant_mem  = 1'b0;
        grant_if   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    grant_mem  = 1'b1;
                    state_next = BUSY_MEM;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    state_next = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (bus_ack || timeout) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            bus_wmask <= 4'b0000;
        end else if (grant_mem) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            bus_wmask <= mem_wmask;
        end else if (grant_if) begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_wdata <= 32'h0;
            bus_wmask <= 4'b0000;
        end else if (finish) begin
            bus_req   <= 1'b0;
        end
    end

    // A timed-out transaction returns zero; a completed store keeps the previous load data.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            if_rdata  <= 32'h0;
            mem_rdata <= 32'h0;
        end else begin
            if_ready  <= finish && (state == BUSY_IF);
            mem_ready <= finish && (state == BUSY_MEM);
            if (finish && (state == BUSY_IF)) begin
                if_rdata <= timeout ? 32'h0 : bus_rdata;
            end
            if (finish && (state == BUSY_MEM)) begin
                if (timeout) begin
                    mem_rdata <= 32'h0;
                end else if (!bus_we) begin
                    mem_rdata <= bus_rdata;
                end
            end
        end
    end

    assign stallreq_from_if  = if_req  & ~if_ready;
    assign stallreq_from_mem = mem_req & ~mem_ready;

endmodule
